// File: rtl/song_player_ctrl_if.sv
// Bus between the song selector / note ROM / tone generator and the playback
// sequencer.
//   song_sel  : selected song index (level)
//   play      : single-cycle play/pause toggle pulse
//   rom_data  : {dur,note} ROM word, valid one cycle after rom_addr
//   rom_addr  : note ROM read address
//   note      : note code presented to the tone generator (0 = rest)
//   tone_en   : tone generator enable
//   playing   : high while actively sequencing
//   song_done : one-cycle pulse when a song ends
// The master modport is the environment side, the slave modport the sequencer.
interface song_player_ctrl_if #(
   parameter int ADDR_W = 8,
   parameter int NOTE_W = 5,
   parameter int DUR_W  = 3
) ();
   logic [2:0]              song_sel;
   logic                    play;
   logic [DUR_W+NOTE_W-1:0] rom_data;
   logic [ADDR_W-1:0]       rom_addr;
   logic [NOTE_W-1:0]       note;
   logic                    tone_en;
   logic                    playing;
   logic                    song_done;

   modport master (
      output song_sel, play, rom_data,
      input  rom_addr, note, tone_en, playing, song_done
   );

   modport slave (
      input  song_sel, play, rom_data,
      output rom_addr, note, tone_en, playing, song_done
   );
endinterface

// File: rtl/song_player_ctrl.sv
// Playback sequencer for the music player.
// Walks the selected song's {dur,note} entries in the note ROM, sounds each
// note for dur beats, then inserts a silent articulation gap. A play pulse
// starts a song from IDLE and toggles pause while running; changing the song
// selection while running restarts at entry 0 of the new song.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : song_player_ctrl_if.slave (song_sel, play, rom_data in;
//          rom_addr, note, tone_en, playing, song_done out, all registered)
module song_player_ctrl #(
   parameter int NUM_SONGS   = 3,
   parameter int SONG_LEN    = 64,
   parameter int ADDR_W      = 8,
   parameter int NOTE_W      = 5,
   parameter int DUR_W       = 3,
   parameter int BEAT_CYCLES = 12_500_000,
   parameter int GAP_CYCLES  = 500_000
) (
   input logic             clk,
   input logic             rst,
   song_player_ctrl_if.slave bus
);
   localparam int SEL_W  = 3;
   localparam int IDX_W  = (SONG_LEN > 1)    ? $clog2(SONG_LEN)    : 1;
   localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1)  ? $clog2(GAP_CYCLES)  : 1;

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SONG_LEN - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, PLAY, GAP, PAUSE} state_t;

   state_t             state, state_nxt;
   state_t             ret_state, ret_nxt;
   logic [SEL_W-1:0]   cur_song, cur_song_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [BEAT_W-1:0]  beat_cnt, beat_nxt;
   logic [DUR_W-1:0]   beats_left, beats_left_nxt;
   logic [GAP_W-1:0]   gap_cnt, gap_nxt;
   logic [NOTE_W-1:0]  note_nxt;
   logic [ADDR_W-1:0]  addr_nxt;
   logic               tone_nxt, playing_nxt, done_nxt;

   logic [SEL_W-1:0]   sel_clamp;
   logic [DUR_W-1:0]   rom_dur;
   logic [NOTE_W-1:0]  rom_note;
   logic               active;
   logic               song_change;

   assign rom_dur     = bus.rom_data[DUR_W+NOTE_W-1:NOTE_W];
   assign rom_note    = bus.rom_data[NOTE_W-1:0];
   assign sel_clamp   = (bus.song_sel >= SEL_W'(NUM_SONGS)) ? SEL_W'(NUM_SONGS - 1)
                                                            : bus.song_sel;
   assign active      = (state == FETCH) || (state == WAIT) ||
                        (state == PLAY)  || (state == GAP);
   assign song_change = (state != IDLE) && (sel_clamp != cur_song);

   always_comb begin
      state_nxt      = state;
      ret_nxt        = ret_state;
      cur_song_nxt   = cur_song;
      idx_nxt        = idx;
      beat_nxt       = beat_cnt;
      beats_left_nxt = beats_left;
      gap_nxt        = gap_cnt;
      note_nxt       = bus.note;
      done_nxt       = 1'b0;

      case (state)
         IDLE: begin
            if (bus.play) begin
               cur_song_nxt = sel_clamp;
               idx_nxt      = '0;
               state_nxt    = FETCH;
            end
         end
         FETCH: state_nxt = WAIT;
         WAIT: begin
            if (rom_dur == '0) begin
               done_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               note_nxt       = rom_note;
               beats_left_nxt = rom_dur;
               beat_nxt       = '0;
               state_nxt      = PLAY;
            end
         end
         PLAY: begin
            if (beat_cnt == BEAT_LAST) begin
               beat_nxt       = '0;
               beats_left_nxt = beats_left - DUR_W'(1);
               if (beats_left == DUR_W'(1)) begin
                  gap_nxt   = '0;
                  state_nxt = GAP;
               end
            end else begin
               beat_nxt = beat_cnt + BEAT_W'(1);
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) begin
               if (idx == IDX_LAST) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  idx_nxt   = idx + IDX_W'(1);
                  state_nxt = FETCH;
               end
            end else begin
               gap_nxt = gap_cnt + GAP_W'(1);
            end
         end
         PAUSE: begin
            if (bus.play) state_nxt = ret_state;
         end
         default: state_nxt = IDLE;
      endcase

      // The cycle in which the pause pulse arrives still completes normally,
      // so the saved state and counters already account for it and resume is
      // cycle-exact. A pulse landing on the song's final cycle lets it end.
      if (bus.play && active && (state_nxt != IDLE)) begin
         ret_nxt   = state_nxt;
         state_nxt = PAUSE;
      end

      // Song change outranks everything, including a simultaneous play pulse.
      if (song_change) begin
         cur_song_nxt   = sel_clamp;
         idx_nxt        = '0;
         beat_nxt       = '0;
         beats_left_nxt = '0;
         gap_nxt        = '0;
         done_nxt       = 1'b0;
         if (state == PAUSE) begin
            state_nxt = PAUSE;
            ret_nxt   = FETCH;
         end else begin
            state_nxt = FETCH;
         end
      end

      // cur_song/idx only move on the way into FETCH, so the address is
      // always ready in the FETCH cycle and held through WAIT.
      addr_nxt    = ADDR_W'(cur_song_nxt) * ADDR_W'(SONG_LEN) + ADDR_W'(idx_nxt);
      tone_nxt    = (state_nxt == PLAY) && (note_nxt != '0);
      playing_nxt = (state_nxt == FETCH) || (state_nxt == WAIT) ||
                    (state_nxt == PLAY)  || (state_nxt == GAP);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         ret_state     <= IDLE;
         cur_song      <= '0;
         idx           <= '0;
         beat_cnt      <= '0;
         beats_left    <= '0;
         gap_cnt       <= '0;
         bus.rom_addr  <= '0;
         bus.note      <= '0;
         bus.tone_en   <= 1'b0;
         bus.playing   <= 1'b0;
         bus.song_done <= 1'b0;
      end else begin
         state         <= state_nxt;
         ret_state     <= ret_nxt;
         cur_song      <= cur_song_nxt;
         idx           <= idx_nxt;
         beat_cnt      <= beat_nxt;
         beats_left    <= beats_left_nxt;
         gap_cnt       <= gap_nxt;
         bus.rom_addr  <= addr_nxt;
         bus.note      <= note_nxt;
         bus.tone_en   <= tone_nxt;
         bus.playing   <= playing_nxt;
         bus.song_done <= done_nxt;
      end
   end
endmodule

// File: tb/tb_song_player_ctrl.sv
// Directed scoreboard bench for song_player_ctrl (BEAT_CYCLES=4, GAP_CYCLES=2,
// SONG_LEN=4, NUM_SONGS=3). Stimulus pushes time-stamped expected output
// values into a queue; a monitor on the falling edge pops and compares the
// entries due in the current cycle. -1 in an expected field means "any".
module tb_song_player_ctrl;
   localparam int ADDR_W = 8;
   localparam int NOTE_W = 5;
   localparam int DUR_W  = 3;

   typedef struct {
      int    cyc;
      string name;
      int    addr;
      int    nt;
      int    te;
      int    pl;
      int    dn;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_vec;
   int   n_bad;
   exp_t q[$];
   logic [DUR_W+NOTE_W-1:0] rom [0:255];

   song_player_ctrl_if #(.ADDR_W(ADDR_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

   song_player_ctrl #(
      .NUM_SONGS(3), .SONG_LEN(4), .ADDR_W(ADDR_W), .NOTE_W(NOTE_W),
      .DUR_W(DUR_W), .BEAT_CYCLES(4), .GAP_CYCLES(2)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous note ROM: data valid one cycle after the address.
   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic ex(input int c, input string nm, input int addr, input int nt,
                     input int te, input int pl, input int dn);
      exp_t e;
      e.cyc = c; e.name = nm; e.addr = addr; e.nt = nt; e.te = te; e.pl = pl; e.dn = dn;
      q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic pulse_play(input int c);
      wait_until(c);
      bus.play = 1'b1;
      wait_until(c + 1);
      bus.play = 1'b0;
   endtask

   function automatic logic [7:0] ent(input int dur, input int nt);
      logic [7:0] w;
      w = {3'(dur), 5'(nt)};
      return w;
   endfunction

   // Monitor / checker
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         logic ok;
         e = q.pop_front();
         ok = (e.cyc == cyc);
         if (e.addr >= 0 && int'(bus.rom_addr)  != e.addr) ok = 1'b0;
         if (e.nt   >= 0 && int'(bus.note)      != e.nt)   ok = 1'b0;
         if (e.te   >= 0 && int'(bus.tone_en)   != e.te)   ok = 1'b0;
         if (e.pl   >= 0 && int'(bus.playing)   != e.pl)   ok = 1'b0;
         if (e.dn   >= 0 && int'(bus.song_done) != e.dn)   ok = 1'b0;
         n_vec = n_vec + 1;
         if (!ok) begin
            n_bad = n_bad + 1;
            $display("FAIL %s @cycle %0d (due %0d): got addr=%0d note=%0d tone_en=%0d playing=%0d song_done=%0d; want addr=%0d note=%0d tone_en=%0d playing=%0d song_done=%0d (-1=any)",
                     e.name, cyc, e.cyc, bus.rom_addr, bus.note, bus.tone_en, bus.playing,
                     bus.song_done, e.addr, e.nt, e.te, e.pl, e.dn);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time, got %0d pending, want 0", q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.play = 1'b0;
      bus.song_sel = 3'd0;
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;

      // Reset state
      ex(2, "reset_outputs", 0, 0, 0, 0, 0);
      ex(4, "idle_after_reset", 0, 0, 0, 0, 0);
      wait_until(3);
      rst = 1'b0;

      // Test 1: song1 = {2,5},{1,0},{0,x}
      rom[4] = ent(2, 5); rom[5] = ent(1, 0); rom[6] = ent(0, 0);
      bus.song_sel = 3'd1;
      t = cyc + 2;
      ex(t,      "t1_idle",        -1, -1, 0, 0, 0);
      ex(t + 1,  "t1_fetch",        4, -1, 0, 1, 0);
      ex(t + 2,  "t1_wait",         4, -1, 0, 1, 0);
      ex(t + 3,  "t1_play_start",   4,  5, 1, 1, 0);
      ex(t + 10, "t1_play_end",     4,  5, 1, 1, 0);
      ex(t + 11, "t1_gap",          4, -1, 0, 1, 0);
      ex(t + 12, "t1_gap_end",     -1, -1, 0, 1, 0);
      ex(t + 13, "t1_fetch2",       5, -1, 0, 1, 0);
      ex(t + 15, "t1_rest",         5,  0, 0, 1, 0);
      ex(t + 18, "t1_rest_end",    -1,  0, 0, 1, 0);
      ex(t + 22, "t1_wait_marker",  6, -1, 0, 1, 0);
      ex(t + 23, "t1_done",         6, -1, 0, 0, 1);
      ex(t + 24, "t1_done_pulse",   6, -1, 0, 0, 0);
      pulse_play(t);
      wait_until(t + 26);

      // Test 2: pause 3 cycles into an 8-cycle note, hold 20 cycles, resume
      rom[0] = ent(2, 7); rom[1] = ent(1, 3); rom[2] = ent(0, 0);
      bus.song_sel = 3'd0;
      t = cyc + 2;
      ex(t + 1,  "t2_fetch",        0, -1, 0, 1, 0);
      ex(t + 5,  "t2_before_pause", 0,  7, 1, 1, 0);
      ex(t + 6,  "t2_paused",       0,  7, 0, 0, 0);
      ex(t + 15, "t2_pause_hold",  -1,  7, 0, 0, 0);
      ex(t + 25, "t2_pause_last",  -1, -1, 0, 0, 0);
      ex(t + 26, "t2_resume",       0,  7, 1, 1, 0);
      ex(t + 30, "t2_resume_last", -1,  7, 1, 1, 0);
      ex(t + 31, "t2_gap",         -1, -1, 0, 1, 0);
      ex(t + 33, "t2_fetch2",       1, -1, 0, 1, 0);
      ex(t + 35, "t2_note2",        1,  3, 1, 1, 0);
      ex(t + 43, "t2_done",         2, -1, 0, 0, 1);
      pulse_play(t);
      pulse_play(t + 5);
      pulse_play(t + 25);
      wait_until(t + 45);

      // Test 3: song_sel 1 -> 2 mid-PLAY
      rom[8] = ent(1, 9); rom[9] = ent(0, 0);
      bus.song_sel = 3'd1;
      t = cyc + 2;
      ex(t + 5,  "t3_play_old",     4,  5, 1, 1, 0);
      ex(t + 6,  "t3_change",       8, -1, 0, 1, 0);
      ex(t + 7,  "t3_addr_new",     8, -1, 0, 1, 0);
      ex(t + 8,  "t3_new_note",     8,  9, 1, 1, 0);
      ex(t + 16, "t3_done",         9, -1, 0, 0, 1);
      pulse_play(t);
      wait_until(t + 5);
      bus.song_sel = 3'd2;
      wait_until(t + 18);

      // Test 4: four non-zero entries, no end marker
      rom[0] = ent(1, 1); rom[1] = ent(1, 2); rom[2] = ent(1, 3); rom[3] = ent(1, 4);
      bus.song_sel = 3'd0;
      t = cyc + 2;
      ex(t + 1,  "t4_e0",           0, -1, 0, 1, 0);
      ex(t + 9,  "t4_e1",           1, -1, 0, 1, 0);
      ex(t + 11, "t4_e1_note",      1,  2, 1, 1, 0);
      ex(t + 17, "t4_e2",           2, -1, 0, 1, 0);
      ex(t + 25, "t4_e3",           3, -1, 0, 1, 0);
      ex(t + 27, "t4_e3_note",      3,  4, 1, 1, 0);
      ex(t + 32, "t4_last_gap",     3, -1, 0, 1, 0);
      ex(t + 33, "t4_done",         3, -1, 0, 0, 1);
      ex(t + 34, "t4_no_wrap",      3, -1, 0, 0, 0);
      pulse_play(t);
      wait_until(t + 36);

      // Test 5: clamp, same-cycle play + song change, reset mid-PLAY
      bus.song_sel = 3'd5;
      t = cyc + 2;
      ex(t + 1,  "t5_clamp",        8, -1, 0, 1, 0);
      ex(t + 3,  "t5_play",         8,  9, 1, 1, 0);
      ex(t + 5,  "t5_change_wins",  0, -1, 0, 1, 0);
      ex(t + 6,  "t5_no_pause",     0, -1, 0, 1, 0);
      ex(t + 7,  "t5_new_song",     0,  1, 1, 1, 0);
      ex(t + 9,  "t5_rst_play",     0,  0, 0, 0, 0);
      ex(t + 10, "t5_rst_idle",     0,  0, 0, 0, 0);
      pulse_play(t);
      wait_until(t + 4);
      bus.song_sel = 3'd0;
      bus.play = 1'b1;
      wait_until(t + 5);
      bus.play = 1'b0;
      wait_until(t + 8);
      rst = 1'b1;
      wait_until(t + 9);
      rst = 1'b0;
      wait_until(t + 12);

      // Test 6: reset mid-PAUSE, then restart at idx 0
      t = cyc + 2;
      ex(t + 9,  "t6_e1",           1, -1, 0, 1, 0);
      ex(t + 11, "t6_e1_note",      1,  2, 1, 1, 0);
      ex(t + 13, "t6_paused",       1,  2, 0, 0, 0);
      ex(t + 14, "t6_pause_hold",   1,  2, 0, 0, 0);
      ex(t + 16, "t6_rst_pause",    0,  0, 0, 0, 0);
      ex(t + 19, "t6_restart",      0, -1, 0, 1, 0);
      ex(t + 21, "t6_restart_note", 0,  1, 1, 1, 0);
      pulse_play(t);
      pulse_play(t + 12);
      wait_until(t + 15);
      rst = 1'b1;
      wait_until(t + 16);
      rst = 1'b0;
      pulse_play(t + 18);
      wait_until(t + 24);

      if (q.size() != 0) begin
         n_bad = n_bad + 1;
         $display("FAIL pending_expectations: got %0d unchecked, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
